md_unit: RTL

Multiply/divide unit for the EX stage of the five-stage pipeline. It owns the HI/LO registers and executes `mult`, `multu`, `div` and `divu` over several cycles. It also services `mthi`, `mtlo`, `mfhi` and `mflo`. `MD_RES` joins the EX result path that feeds the EX/MEM register and, from there, `MEM_WD`. `MD_start`/`MD_busy` go to the hazard unit so ID stalls on any MD-class instruction while a multi-cycle operation is in progress.

---
 rtl/md_unit_pkg.sv | 31 +++
 rtl/md_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - MD op encodings, FSM states and op classification for md_unit
package md_unit_pkg;

    typedef enum logic [3:0] {
        mdNone  = 4'd0,
        mdMult  = 4'd1,
        mdMultu = 4'd2,
        mdDiv   = 4'd3,
        mdDivu  = 4'd4,
        mdMthi  = 4'd5,
        mdMtlo  = 4'd6,
        mdMfhi  = 4'd7,
        mdMflo  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int CNT_W = 4;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == mdMult) || (op == mdMultu) || (op == mdDiv) || (op == mdDivu);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == mdDiv) || (op == mdDivu);
    endfunction

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning HI/LO for the EX stage
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MD_op,
    input  logic [31:0] MD_A,
    input  logic [31:0] MD_B,
    output logic        MD_start,
    output logic        MD_busy,
    output logic [31:0] MD_RES
);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q;
    logic [63:0]        pend_q;
    logic               pend_wr_q;

    logic [63:0]        res_d;
    logic               res_wr_d;
    logic [CNT_W-1:0]   cnt_d;

    logic [31:0]        b_safe;
    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;

    // A zero divisor is replaced so the dividers never see it; the result is dropped anyway.
    assign b_safe = (MD_B == 32'd0) ? 32'd1 : MD_B;
    assign prod_s = {{32{MD_A[31]}}, MD_A} * {{32{MD_B[31]}}, MD_B};
    assign prod_u = {32'd0, MD_A} * {32'd0, MD_B};
    assign quo_s  = $signed(MD_A) / $signed(b_safe);
    assign rem_s  = $signed(MD_A) % $signed(b_safe);
    assign quo_u  = MD_A / b_safe;
    assign rem_u  = MD_A % b_safe;

    always_comb begin
        res_d    = 64'd0;
        res_wr_d = 1'b1;
        cnt_d    = CNT_W'(MULT_CYCLES);
        case (MD_op)
            mdMult:  res_d = prod_s;
            mdMultu: res_d = prod_u;
            mdDiv:   res_d = {rem_s, quo_s};
            mdDivu:  res_d = {rem_u, quo_u};
            default: res_d = 64'd0;
        endcase
        if (is_div(MD_op)) begin
            cnt_d    = CNT_W'(DIV_CYCLES);
            res_wr_d = (MD_B != 32'd0);
        end
    end

    assign MD_start = is_multi(MD_op) && (state_q == ST_IDLE);
    assign MD_busy  = (state_q == ST_BUSY);

    always_comb begin
        MD_RES = 32'd0;
        if (MD_op == mdMfhi) MD_RES = hi_q;
        else if (MD_op == mdMflo) MD_RES = lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MD_start) begin
                        pend_q    <= res_d;
                        pend_wr_q <= res_wr_d;
                        cnt_q     <= cnt_d;
                        state_q   <= ST_BUSY;
                    end else if (MD_op == mdMthi) begin
                        hi_q <= MD_A;
                    end else if (MD_op == mdMtlo) begin
                        lo_q <= MD_A;
                    end
                end
                ST_BUSY: begin
                    // Ops arriving here are ignored; only the countdown advances.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        if (pend_wr_q) {hi_q, lo_q} <= pend_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
